// File: rtl/pp_pkg.sv
// Shared types and helpers for the partial-product row streamer.
// The nibble-search helpers are only referenced when ZERO_SKIP_EN is defined.
package pp_pkg;

    localparam int ROWS_PER_BEAT = 4;
    localparam int MAX_N         = 64;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    function automatic int beats(input int n);
        return n / ROWS_PER_BEAT;
    endfunction

    // Lowest beat index above g whose multiplier nibble is nonzero; beats(n) if none.
    function automatic int next_nz(input logic [MAX_N-1:0] b, input int n, input int g);
        int               r;
        logic [MAX_N-1:0] t;
        r = beats(n);
        for (int i = MAX_N / 4 - 1; i >= 0; i--) begin
            t = b >> (4 * i);
            if (i > g && i < beats(n) && t[3:0] != 4'h0) begin
                r = i;
            end
        end
        return r;
    endfunction

    // First nonzero beat; an all-zero multiplier still produces beat 0.
    function automatic int first_nz(input logic [MAX_N-1:0] b, input int n);
        int r;
        r = next_nz(b, n, -1);
        if (r >= beats(n)) begin
            r = 0;
        end
        return r;
    endfunction

endpackage

// File: rtl/pp_row_gen.sv
// Combinational AND-array slice: four partial-product rows for beat g.
// Row k is A shifted by 4g+k when multiplier bit 4g+k is set, else zero.
module pp_row_gen
    import pp_pkg::*;
#(
    parameter int N  = 8,
    parameter int BW = 1
) (
    input  logic [N-1:0]                 i_a,
    input  logic [N-1:0]                 i_b,
    input  logic [BW-1:0]                i_g,
    output logic [2*N*ROWS_PER_BEAT-1:0] o_rows
);

    logic [2*N-1:0] w_a_ext;
    logic [N-1:0]   w_b_sh;

    assign w_a_ext = {{N{1'b0}}, i_a};
    assign w_b_sh  = i_b >> {i_g, 2'b00};

    for (genvar k = 0; k < ROWS_PER_BEAT; k++) begin : g_row
        localparam logic [1:0] KK = 2'(k);
        logic [BW+1:0] w_sh;
        assign w_sh = {i_g, KK};
        assign o_rows[2*N*k +: 2*N] = w_b_sh[k] ? (w_a_ext << w_sh) : '0;
    end

endmodule

// File: rtl/pp_row_streamer.sv
// Streams the partial-product rows of one A*B pair, four rows per beat.
// Define ZERO_SKIP_EN to skip beats whose multiplier nibble is zero.
module pp_row_streamer
    import pp_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                                                      clk,
    input  logic                                                      rst,
    input  logic                                                      in_valid,
    output logic                                                      in_ready,
    input  logic [N-1:0]                                              in_a,
    input  logic [N-1:0]                                              in_b,
    output logic                                                      out_valid,
    input  logic                                                      out_ready,
    output logic [2*N*ROWS_PER_BEAT-1:0]                              out_rows,
    output logic [((beats(N) > 1) ? $clog2(beats(N)) : 1)-1:0]        out_beat,
    output logic                                                      out_last,
    output logic                                                      busy,
    output state_t                                                    dbg_state
);

    localparam int NB = beats(N);
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    // Handshake: a pair is taken when in_valid & in_ready; a beat moves when
    // out_valid & out_ready, and the beat outputs hold steady until it moves.
    state_t         r_state;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [BW-1:0]  r_g;
    logic           r_valid;
    logic           r_in_ready;

    logic           w_last;
    logic [BW-1:0]  w_next_g;
    logic [BW-1:0]  w_first_g;

`ifdef ZERO_SKIP_EN
    logic [MAX_N-1:0] w_b_ext;
    logic [MAX_N-1:0] w_in_b_ext;
    int               w_nz;

    always_comb begin
        w_b_ext           = '0;
        w_b_ext[N-1:0]    = r_b;
        w_in_b_ext        = '0;
        w_in_b_ext[N-1:0] = in_b;
        w_nz              = next_nz(w_b_ext, N, int'(r_g));
        w_last            = (w_nz >= NB);
        w_next_g          = BW'(w_nz);
        w_first_g         = BW'(first_nz(w_in_b_ext, N));
    end
`else
    always_comb begin
        w_last    = (r_g == BW'(NB - 1));
        w_next_g  = r_g + BW'(1);
        w_first_g = '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_g        <= '0;
            r_valid    <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_g        <= w_first_g;
                        r_valid    <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_state    <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (w_last) begin
                            r_valid    <= 1'b0;
                            r_in_ready <= 1'b1;
                            r_state    <= IDLE;
                        end else begin
                            r_g <= w_next_g;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    pp_row_gen #(
        .N  (N),
        .BW (BW)
    ) u_row_gen (
        .i_a    (r_a),
        .i_b    (r_b),
        .i_g    (r_g),
        .o_rows (out_rows)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = r_valid;
    assign out_beat  = r_g;
    assign out_last  = r_valid & w_last;
    assign busy      = (r_state == EMIT);
    assign dbg_state = r_state;

endmodule
